// File: rtl/game_pkg.sv
// Shared definitions for the game state controller.
//   game_state_e : FSM state enumeration with its fixed 3-bit encoding
//   BCD_DIGIT_W  : width of one BCD digit
//   BCD_DIGITS   : number of BCD digits in the score
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_DYING   = 3'd2,
        ST_CROSSED = 3'd3,
        ST_OVER    = 3'd4
    } game_state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 4;

endpackage

// File: rtl/bcd_incr4.sv
// Combinational four-digit BCD incrementer, saturating at 9999.
//   bcd_i : 16-bit BCD value (four digits)
//   bcd_o : bcd_i + 1 in BCD, or 9999 when bcd_i is already 9999
module bcd_incr4
    import game_pkg::*;
(
    input  logic [BCD_DIGITS*BCD_DIGIT_W-1:0] bcd_i,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] bcd_o
);

    logic carry;

    always_comb begin
        bcd_o = bcd_i;
        carry = 1'b1;
        if (bcd_i != 16'h9999) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (carry) begin
                    // A 9 rolls to 0 and passes the carry on; anything else absorbs it.
                    if (bcd_i[d*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                        bcd_o[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                    end else begin
                        bcd_o[d*BCD_DIGIT_W +: BCD_DIGIT_W] =
                            bcd_i[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencing controller: lives, score, level, death/cross timers.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   start      : start button level (edge-detected)
//   die        : collision flag level (edge-detected)
//   win        : far-bank flag level (edge-detected)
//   frog_reset : one-cycle pulse returning the frog to its start position
//   freeze     : high while frog and crocs must hold position
//   lives      : remaining lives
//   score_bcd  : four-digit BCD score
//   level      : speed level, saturating at MAX_LEVEL
//   state      : current FSM state encoding
//   blink      : frog sprite flash enable
//
// state   | meaning
// IDLE    | waiting for start after reset
// PLAY    | game running, frog and crocs moving
// DYING   | death animation, blink toggling, timer running
// CROSSED | frog reached far bank, timer running
// OVER    | no lives left, score held until start
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int DEATH_CYCLES = 25_000_000,
    parameter int CROSS_CYCLES = 12_500_000,
    parameter int BLINK_CYCLES = 3_125_000,
    parameter int MAX_LEVEL    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        die,
    input  logic        win,
    output logic        frog_reset,
    output logic        freeze,
    output logic [1:0]  lives,
    output logic [15:0] score_bcd,
    output logic [3:0]  level,
    output logic [2:0]  state,
    output logic        blink
);

    localparam int TMR_MAX = (DEATH_CYCLES > CROSS_CYCLES) ? DEATH_CYCLES : CROSS_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_CYCLES + 1);

    game_state_e       state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [15:0]       score_q, score_d;
    logic [3:0]        level_q, level_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [BLK_W-1:0]  bcnt_q, bcnt_d;
    logic              blink_q, blink_d;
    logic              frog_reset_q, frog_reset_d;
    logic              freeze_q, freeze_d;
    logic              start_prev_q, die_prev_q, win_prev_q;

    logic              start_ev, die_ev, win_ev;
    logic [15:0]       score_inc;

    assign start_ev = start & ~start_prev_q;
    assign die_ev   = die   & ~die_prev_q;
    assign win_ev   = win   & ~win_prev_q;

    bcd_incr4 u_bcd_incr4 (
        .bcd_i (score_q),
        .bcd_o (score_inc)
    );

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        level_d      = level_q;
        timer_d      = timer_q;
        bcnt_d       = bcnt_q;
        blink_d      = blink_q;
        frog_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_ev) begin
                    state_d      = ST_PLAY;
                    lives_d      = 2'(LIVES_INIT);
                    score_d      = 16'h0000;
                    level_d      = 4'd1;
                    timer_d      = '0;
                    frog_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // die takes priority over a simultaneous win.
                if (die_ev) begin
                    state_d = ST_DYING;
                    lives_d = lives_q - 2'd1;
                    timer_d = TMR_W'(DEATH_CYCLES - 1);
                    bcnt_d  = BLK_W'(BLINK_CYCLES - 1);
                    blink_d = 1'b1;
                end else if (win_ev) begin
                    state_d = ST_CROSSED;
                    score_d = score_inc;
                    if (level_q < 4'(MAX_LEVEL)) begin
                        level_d = level_q + 4'd1;
                    end
                    timer_d = TMR_W'(CROSS_CYCLES - 1);
                end
            end
            ST_DYING: begin
                if (timer_q == '0) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d      = ST_PLAY;
                        frog_reset_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                    if (bcnt_q == '0) begin
                        blink_d = ~blink_q;
                        bcnt_d  = BLK_W'(BLINK_CYCLES - 1);
                    end else begin
                        bcnt_d = bcnt_q - BLK_W'(1);
                    end
                end
            end
            ST_CROSSED: begin
                if (timer_q == '0) begin
                    state_d      = ST_PLAY;
                    frog_reset_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // blink only animates inside DYING; it rests high everywhere else.
        if (state_d != ST_DYING) begin
            blink_d = 1'b1;
        end
        freeze_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lives_q      <= 2'd0;
            score_q      <= 16'h0000;
            level_q      <= 4'd1;
            timer_q      <= '0;
            bcnt_q       <= '0;
            blink_q      <= 1'b1;
            frog_reset_q <= 1'b0;
            freeze_q     <= 1'b1;
            // Inputs already high at reset release must not count as events.
            start_prev_q <= 1'b1;
            die_prev_q   <= 1'b1;
            win_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            bcnt_q       <= bcnt_d;
            blink_q      <= blink_d;
            frog_reset_q <= frog_reset_d;
            freeze_q     <= freeze_d;
            start_prev_q <= start;
            die_prev_q   <= die;
            win_prev_q   <= win;
        end
    end

    assign frog_reset = frog_reset_q;
    assign freeze     = freeze_q;
    assign lives      = lives_q;
    assign score_bcd  = score_q;
    assign level      = level_q;
    assign state      = state_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

    localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_CROSSED = 3, S_OVER = 4;

    logic        clk = 1'b0;
    logic        rst, start, die, win;
    logic        frog_reset, freeze, blink;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic [3:0]  level;
    logic [2:0]  state;
    logic [15:0] bcd_in, bcd_out;

    int n_assert = 0;
    int n_fail   = 0;

    // model of the game at the level of rules, not of the hardware
    int m_lives, m_score, m_level;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .LIVES_INIT   (3),
        .DEATH_CYCLES (8),
        .CROSS_CYCLES (4),
        .BLINK_CYCLES (2),
        .MAX_LEVEL    (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .die        (die),
        .win        (win),
        .frog_reset (frog_reset),
        .freeze     (freeze),
        .lives      (lives),
        .score_bcd  (score_bcd),
        .level      (level),
        .state      (state),
        .blink      (blink)
    );

    bcd_incr4 u_bcd (.bcd_i(bcd_in), .bcd_o(bcd_out));

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
        chk({tag, ".score"}, 32'(score_bcd), 32'(to_bcd(m_score)));
        chk({tag, ".level"}, 32'(level), 32'(m_level));
    endtask

    // Wait, bounded, until the timed states finish.
    task automatic settle();
        for (int i = 0; i < 40; i++) begin
            if (state == 3'(S_PLAY) || state == 3'(S_OVER)) break;
            tick();
        end
    endtask

    task automatic new_game();
        m_lives = 3;
        m_score = 0;
        m_level = 1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; die = 1'b0; win = 1'b0;
        bcd_in = 16'h0000;
        tick(); tick(); tick();
        chk("rst.state", 32'(state), S_IDLE);
        chk("rst.lives", 32'(lives), 0);
        chk("rst.score", 32'(score_bcd), 0);
        chk("rst.level", 32'(level), 1);
        chk("rst.freeze", 32'(freeze), 1);
        chk("rst.blink", 32'(blink), 1);
        chk("rst.frog_reset", 32'(frog_reset), 0);

        // start held across reset release is not an event
        rst = 1'b0;
        tick(); tick();
        chk("start_held.state", 32'(state), S_IDLE);
        start = 1'b0; tick();
        start = 1'b1; tick();
        new_game();
        chk("start.state", 32'(state), S_PLAY);
        chk("start.frog_reset", 32'(frog_reset), 1);
        chk("start.freeze", 32'(freeze), 0);
        chk_model("start");
        start = 1'b0; tick();
        chk("start.frog_reset_once", 32'(frog_reset), 0);

        // die held for 20 cycles: one death, 8 cycles of DYING
        die = 1'b1; tick();
        m_lives--;
        chk_model("die");
        for (int i = 0; i < 8; i++) begin
            chk("dying.state", 32'(state), S_DYING);
            chk("dying.freeze", 32'(freeze), 1);
            chk("dying.blink", 32'(blink), ((i / 2) % 2 == 0) ? 1 : 0);
            tick();
        end
        chk("dying_end.state", 32'(state), S_PLAY);
        chk("dying_end.frog_reset", 32'(frog_reset), 1);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("die_held.state", 32'(state), S_PLAY);
        end
        chk_model("die_held");
        die = 1'b0; tick();

        // three crossings
        for (int k = 0; k < 3; k++) begin
            win = 1'b1; tick(); win = 1'b0;
            m_score++; m_level++;
            for (int i = 0; i < 4; i++) begin
                chk("crossed.state", 32'(state), S_CROSSED);
                chk("crossed.freeze", 32'(freeze), 1);
                tick();
            end
            chk("crossed_end.state", 32'(state), S_PLAY);
            chk("crossed_end.frog_reset", 32'(frog_reset), 1);
        end
        chk_model("three_wins");

        // die and win on the same edge
        die = 1'b1; win = 1'b1; tick(); die = 1'b0; win = 1'b0;
        m_lives--;
        chk("both.state", 32'(state), S_DYING);
        chk_model("both");
        settle();

        // third death ends the game
        die = 1'b1; tick(); die = 1'b0;
        m_lives--;
        for (int i = 0; i < 8; i++) tick();
        chk("over.state", 32'(state), S_OVER);
        chk("over.freeze", 32'(freeze), 1);
        chk_model("over");
        die = 1'b1; win = 1'b1; tick(); die = 1'b0; win = 1'b0; tick();
        chk("over_ignore.state", 32'(state), S_OVER);
        chk_model("over_ignore");
        start = 1'b1; tick(); start = 1'b0;
        new_game();
        chk("restart.state", 32'(state), S_PLAY);
        chk("restart.frog_reset", 32'(frog_reset), 1);
        chk_model("restart");
        tick();

        // randomized play against the rule model
        for (int it = 0; it < 40; it++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                win = 1'b1; tick(); win = 1'b0;
                if (m_score < 9999) m_score++;
                if (m_level < 9) m_level++;
                chk("rnd_win.state", 32'(state), S_CROSSED);
            end else if (r == 3) begin
                start = 1'b1; tick(); start = 1'b0;
                chk("rnd_start.state", 32'(state), S_PLAY);
            end else begin
                die = 1'b1; win = (r == 2); tick(); die = 1'b0; win = 1'b0;
                m_lives--;
                chk("rnd_die.state", 32'(state), S_DYING);
            end
            tick();
            settle();
            chk_model("rnd");
            if (m_lives == 0) begin
                chk("rnd_over.state", 32'(state), S_OVER);
                start = 1'b1; tick(); start = 1'b0;
                new_game();
                chk("rnd_restart.state", 32'(state), S_PLAY);
                tick();
            end else begin
                chk("rnd_play.state", 32'(state), S_PLAY);
            end
        end

        // drive the score to 999, then carry across three digits
        rst = 1'b1; tick(); rst = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        new_game();
        for (int k = 0; k < 999; k++) begin
            win = 1'b1; tick(); win = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            m_score++;
            if (m_level < 9) m_level++;
        end
        chk("s0999.state", 32'(state), S_PLAY);
        chk_model("s0999");
        chk("s0999.score", 32'(score_bcd), 32'h0999);
        win = 1'b1; tick(); win = 1'b0;
        m_score++;
        chk("s1000.score", 32'(score_bcd), 32'h1000);
        chk("level_sat", 32'(level), 9);
        settle();

        // reset in the middle of DYING
        die = 1'b1; tick(); die = 1'b0;
        tick(); tick(); tick();
        chk("mid_dying.state", 32'(state), S_DYING);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_dying.state", 32'(state), S_IDLE);
        chk("rst_dying.lives", 32'(lives), 0);
        chk("rst_dying.score", 32'(score_bcd), 0);
        chk("rst_dying.level", 32'(level), 1);
        chk("rst_dying.freeze", 32'(freeze), 1);
        chk("rst_dying.blink", 32'(blink), 1);

        // incrementer boundaries and random values
        bcd_in = 16'h9999; #1;
        chk("bcd_sat", 32'(bcd_out), 32'h9999);
        bcd_in = 16'h0999; #1;
        chk("bcd_carry", 32'(bcd_out), 32'h1000);
        for (int i = 0; i < 30; i++) begin
            int v;
            v = int'($urandom_range(0, 9999));
            bcd_in = to_bcd(v); #1;
            chk("bcd_rnd", 32'(bcd_out), 32'(to_bcd((v == 9999) ? 9999 : v + 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LIVES_INIT, 3, lives loaded at game start (1..3).
- DEATH_CYCLES, 25_000_000, clk cycles held in DYING.
- CROSS_CYCLES, 12_500_000, clk cycles held in CROSSED.
- BLINK_CYCLES, 3_125_000, half-period of blink during DYING.
- MAX_LEVEL, 9, level saturation value (1..15).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; the block has one clock.
- rst, in, 1, reset; synchronous and active-high.
- start, in, 1, debounced start button, level.
- die, in, 1, collision flag from the eaten checker, level, may stay high for many cycles.
- win, in, 1, frog-reached-far-bank flag from the frog block, level.
- frog_reset, out, 1, one-cycle pulse that returns the frog to its start position.
- freeze, out, 1, high while frog and crocs must hold position.
- lives, out, 2, remaining lives.
- score_bcd, out, 16, four BCD digits feeding the seven-segment scoreboard.
- level, out, 4, speed level consumed by the croc speed inputs.
- state, out, 3, current FSM state encoding.
- blink, out, 1, flash enable for the frog sprite.

Function
REQ-003 start, die and win SHALL each be edge-detected using a registered previous value; an event is input=1 at a clock edge where prev=0.
REQ-004 The state transition and all register updates caused by an event SHALL occur at that same clock edge; all outputs SHALL be registered.
REQ-005 FSM states SHALL be IDLE, PLAY, DYING, CROSSED and OVER.
REQ-006 In IDLE, a start event SHALL take the FSM to PLAY and SHALL load lives=LIVES_INIT, score_bcd=0x0000 and level=1, with a frog_reset pulse.
REQ-007 In PLAY, a die event SHALL take the FSM to DYING, decrement lives by 1 and load the timer with DEATH_CYCLES-1.
REQ-008 In PLAY, a win event SHALL take the FSM to CROSSED, BCD-increment score_bcd, increment level saturating at MAX_LEVEL, and load the timer with CROSS_CYCLES-1.
REQ-009 A die event and a win event in the same cycle SHALL be handled as die only; score and level SHALL be unchanged.
REQ-010 In DYING, when the timer reaches 0: if lives==0 the FSM SHALL go to OVER; otherwise it SHALL go to PLAY with a frog_reset pulse.
REQ-011 In CROSSED, when the timer reaches 0, the FSM SHALL go to PLAY with a frog_reset pulse.
REQ-012 In OVER, score_bcd and level SHALL hold their values; a start event SHALL restart the game exactly as in REQ-006.
REQ-013 freeze SHALL be 0 only in PLAY; it SHALL be 1 in every other state.
REQ-014 blink SHALL toggle every BLINK_CYCLES cycles while in DYING; it SHALL be 1 in every other state and SHALL be 1 on entry to DYING.
REQ-015 Events not listed for the current state SHALL be ignored: start outside IDLE/OVER, and die/win outside PLAY.
REQ-016 The score SHALL saturate at BCD 9999; no digit SHALL ever hold a value above 9.
REQ-017 The timer SHALL be wide enough for max(DEATH_CYCLES, CROSS_CYCLES) and SHALL count down only in DYING and CROSSED.
REQ-018 frog_reset SHALL be high for exactly one cycle per qualifying transition.

Reset
REQ-019 On rst, the block SHALL enter IDLE with lives=0, score_bcd=0x0000, level=1, freeze=1, blink=1, frog_reset=0, timer=0.
REQ-020 On rst, all edge-detect prev registers SHALL be set to 1, so that an input already high at reset release is not an event.
REQ-021 rst asserted in any state, including mid-timer, SHALL take effect at the next clock edge and SHALL override every event in that cycle.

Structure
REQ-022 A shared package game_pkg SHALL hold the state enumeration and its 3-bit encoding (IDLE=0, PLAY=1, DYING=2, CROSSED=3, OVER=4) and the BCD digit width constant.
REQ-023 The BCD increment SHALL be a sub-module bcd_incr4, combinational, 16-bit in/out, saturating at 9999.

Verification
All scenarios use DEATH_CYCLES=8, CROSS_CYCLES=4, BLINK_CYCLES=2, LIVES_INIT=3, MAX_LEVEL=9.
REQ-024 rst, then start held high through reset release -> FSM stays in IDLE; after start goes low then high -> PLAY, lives=3, score=0x0000, level=1, one frog_reset pulse.
REQ-025 In PLAY, die held high for 20 cycles -> exactly one decrement (lives=2); DYING lasts 8 cycles; blink pattern 1,1,0,0,1,1,0,0; then PLAY with a frog_reset pulse.
REQ-026 Three win events, each allowed to finish CROSSED -> score=0x0003, level=4; each CROSSED lasts 4 cycles with freeze=1.
REQ-027 die and win rising in the same cycle -> DYING, score and level unchanged.
REQ-028 Three deaths -> OVER with lives=0 and score held; a start event -> PLAY, lives=3, score=0x0000.
REQ-029 score preloaded to 0x0999 then a win event -> 0x1000; score at 0x9999 then a win event -> stays 0x9999; level at 9 then a win event -> stays 9; rst asserted mid-DYING -> IDLE on the next cycle.
